// File: rtl/mpc_pkg.sv
// Shared types for the MPC constraint-vector read side.
// Q16.16 entry type, saturated bound constant and reader FSM states.
package mpc_pkg;

    typedef logic signed [31:0] q16_16_t;

    localparam q16_16_t Q16_MAX = 32'h7FFF_FFFF;

    // Total reads allowed between BRAM issue and stream output.
    localparam int CREDITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/mpc_skid_fifo2.sv
// Two-entry valid/ready buffer between the BRAM read port and the stream.
// Ports: ap_clk/ap_rst_n, in_valid/in_data push side, out_* pop side,
// pop (transfer this cycle) and level (entries held) for the credit logic.
module mpc_skid_fifo2 #(
    parameter int W = 33
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         pop,
    output logic [1:0]   level
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;

    assign out_valid = (level != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // The upstream credit check keeps this from ever being full on a push;
    // the guard only protects the stored entries.
    assign push      = in_valid && ((level != 2'd2) || pop);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mpc_constraint_vec_reader.sv
// Streams a slice of h[] out of its BRAM and tracks the signed minimum.
// Ports: ap_* start/done handshake, base_addr/count slice, h_* BRAM read
// port, out_* valid/ready stream with last marker, min_val result.
module mpc_constraint_vec_reader
    import mpc_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] h_address0,
    output logic              h_ce0,
    input  logic [DATA_W-1:0] h_q0,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [DATA_W-1:0] min_val
);

    rd_state_e         state;
    rd_state_e         state_nx;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   issue_left;
    logic              inflight;
    logic              inflight_last;
    logic              start_acc;
    logic              issue;
    logic              issue_last;
    logic              pop;
    logic [1:0]        level;
    logic [1:0]        occ_after;
    logic [1:0]        credit_used;

    // Occupancy is taken after this cycle's pop so the stream can run at
    // one entry per cycle with one read always in flight.
    assign occ_after   = level - {1'b0, pop};
    assign credit_used = occ_after + {1'b0, inflight};
    assign issue_last  = (issue_left == {{ADDR_W{1'b0}}, 1'b1});
    assign start_acc   = (state == ST_IDLE) && ap_start;

    assign h_address0 = rd_addr;
    assign h_ce0      = issue;
    assign ap_idle    = (state == ST_IDLE) && !ap_start;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ap_start) begin
                    if (count != '0) state_nx = ST_READ;
                    else             state_nx = ST_DONE;
                end
            end
            ST_READ: begin
                issue = (issue_left != '0) &&
                        (credit_used < 2'(CREDITS));
                if (issue && issue_last) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight && (occ_after == 2'd0)) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_addr       <= '0;
            issue_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (start_acc) begin
                rd_addr    <= base_addr;
                issue_left <= count;
            end else if (issue) begin
                // Natural wrap modulo 2**ADDR_W.
                rd_addr    <= rd_addr + 1'b1;
                issue_left <= issue_left - 1'b1;
            end
            inflight      <= issue;
            inflight_last <= issue && issue_last;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            min_val <= DATA_W'(Q16_MAX);
        end else if (start_acc) begin
            min_val <= DATA_W'(Q16_MAX);
        end else if (pop && ($signed(out_data) < $signed(min_val))) begin
            min_val <= out_data;
        end
    end

    mpc_skid_fifo2 #(
        .W(DATA_W + 1)
    ) u_fifo (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (inflight),
        .in_data   ({inflight_last, h_q0}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_last, out_data}),
        .pop       (pop),
        .level     (level)
    );

endmodule

// File: tb/tb_mpc_constraint_vec_reader.sv
// Directed bench for mpc_constraint_vec_reader.
// BRAM model with one-cycle read latency; sampling on the falling edge.
module tb_mpc_constraint_vec_reader;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  base_addr = '0;
    logic [5:0]  count = '0;
    logic [4:0]  h_address0;
    logic        h_ce0;
    logic [31:0] h_q0 = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [31:0] min_val;

    mpc_constraint_vec_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .base_addr(base_addr), .count(count),
        .h_address0(h_address0), .h_ce0(h_ce0), .h_q0(h_q0),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .min_val(min_val)
    );

    always #5 ap_clk = ~ap_clk;

    logic [31:0] mem [32];
    always @(posedge ap_clk) if (h_ce0) h_q0 <= mem[h_address0];

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] got_data [$];
    logic        got_last [$];
    logic [4:0]  got_addr [$];
    int done_cnt, done_cyc, first_vld, max_out, stall_err, rdy_err, tmo;
    logic [31:0] min_at_done;

    task automatic run_slice(input logic [4:0] b, input logic [5:0] c,
                             input int mode, input int budget);
        int issued, xfer, k, extra;
        logic pstall, plast;
        logic [31:0] pdata;
        got_data.delete(); got_last.delete(); got_addr.delete();
        done_cnt = 0; done_cyc = -1; first_vld = -1; max_out = 0;
        stall_err = 0; rdy_err = 0; tmo = 0; min_at_done = '0;
        issued = 0; xfer = 0; k = 0; extra = -1;
        pstall = 1'b0; plast = 1'b0; pdata = '0;
        @(negedge ap_clk);
        ap_start = 1'b1; base_addr = b; count = c; out_ready = 1'b1;
        forever begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            out_ready = (mode == 0) || (k % 3 == 0);
            #1;
            if (h_ce0) begin got_addr.push_back(h_address0); issued++; end
            if (pstall && (!out_valid || out_data !== pdata ||
                           out_last !== plast)) stall_err++;
            if (out_valid && first_vld < 0) first_vld = k;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                xfer++;
            end
            if (issued - xfer > max_out) max_out = issued - xfer;
            pstall = out_valid && !out_ready;
            pdata = out_data; plast = out_last;
            if (ap_ready !== ap_done) rdy_err++;
            if (ap_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k; min_at_done = min_val; extra = 3;
                end
            end
            k++;
            if (extra == 0) break;
            if (extra > 0) extra--;
            if (k >= budget) begin tmo = 1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge ap_clk);
        #1;
        n_tests++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", ap_done); end
        n_tests++; if (ap_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", ap_ready); end
        n_tests++; if (h_ce0 !== 1'b0) begin n_fail++; $display("FAIL rst_ce0 got %b want 0", h_ce0); end
        n_tests++; if (h_address0 !== 5'd0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", h_address0); end
        n_tests++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL rst_valid_last got %b%b want 00", out_valid, out_last); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", out_data); end
        n_tests++; if (min_val !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL rst_min got %h want 7fffffff", min_val); end
        n_tests++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b want 1", ap_idle); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 20; i < 24; i++) mem[i] = 32'd655360;
        run_slice(5'd20, 6'd4, 0, 40);
        n_tests++; if (tmo != 0 || got_data.size() != 4) begin n_fail++; $display("FAIL t1_count got %0d want 4 (tmo %0d)", got_data.size(), tmo); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_tests++; if (got_data[i] !== 32'd655360 || got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL t1_entry%0d got %h/%b want 000a0000/%b", i, got_data[i], got_last[i], i == 3); end
        end
        n_tests++; if (first_vld != 2) begin n_fail++; $display("FAIL t1_first_valid got %0d want 2", first_vld); end
        n_tests++; if (done_cyc != 6) begin n_fail++; $display("FAIL t1_done_cycle got %0d want 6", done_cyc); end
        n_tests++; if (done_cnt != 1 || rdy_err != 0) begin n_fail++; $display("FAIL t1_done_pulse got %0d/%0d want 1/0", done_cnt, rdy_err); end
        n_tests++; if (min_at_done !== 32'd655360) begin n_fail++; $display("FAIL t1_min got %h want 000a0000", min_at_done); end
    endtask

    task automatic test_min();
        logic [31:0] exp [4];
        exp = '{32'd327680, 32'hFFFD_8000, 32'd458752, 32'hFFFD_8000};
        for (int i = 0; i < 4; i++) mem[i] = exp[i];
        run_slice(5'd0, 6'd4, 0, 40);
        n_tests++; if (tmo != 0 || got_data.size() != 4) begin n_fail++; $display("FAIL t2_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_tests++; if (got_data[i] !== exp[i]) begin n_fail++; $display("FAIL t2_entry%0d got %h want %h", i, got_data[i], exp[i]); end
        end
        n_tests++; if (min_at_done !== 32'hFFFD_8000) begin n_fail++; $display("FAIL t2_min got %h want fffd8000", min_at_done); end
        n_tests++; if (min_val !== 32'hFFFD_8000) begin n_fail++; $display("FAIL t2_min_held got %h want fffd8000", min_val); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) mem[20 + i] = 32'd655360 + 32'(i) * 32'd65536;
        run_slice(5'd20, 6'd4, 1, 80);
        n_tests++; if (tmo != 0 || got_data.size() != 4) begin n_fail++; $display("FAIL t3_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_tests++; if (got_data[i] !== 32'd655360 + 32'(i) * 32'd65536 || got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL t3_entry%0d got %h/%b", i, got_data[i], got_last[i]); end
        end
        n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL t3_stall_stable got %0d want 0", stall_err); end
        n_tests++; if (max_out > 2) begin n_fail++; $display("FAIL t3_outstanding got %0d want <=2", max_out); end
        n_tests++; if (done_cnt != 1 || min_at_done !== 32'd655360) begin n_fail++; $display("FAIL t3_done_min got %0d/%h want 1/000a0000", done_cnt, min_at_done); end
    endtask

    task automatic test_wrap();
        logic [4:0] ea [4];
        ea = '{5'd30, 5'd31, 5'd0, 5'd1};
        for (int i = 0; i < 4; i++) mem[ea[i]] = 32'h100 + 32'(i);
        run_slice(5'd30, 6'd4, 0, 40);
        n_tests++; if (tmo != 0 || got_addr.size() != 4 || got_data.size() != 4) begin n_fail++; $display("FAIL t4_count got %0d/%0d want 4/4", got_addr.size(), got_data.size()); end
        for (int i = 0; i < got_addr.size() && i < got_data.size(); i++) begin
            n_tests++; if (got_addr[i] !== ea[i] || got_data[i] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL t4_read%0d got %0d/%h want %0d/%h", i, got_addr[i], got_data[i], ea[i], 32'h100 + 32'(i)); end
        end
    endtask

    task automatic test_zero();
        run_slice(5'd7, 6'd0, 0, 20);
        n_tests++; if (done_cyc != 0 || done_cnt != 1 || rdy_err != 0) begin n_fail++; $display("FAIL t5_done got cyc %0d cnt %0d want 0/1", done_cyc, done_cnt); end
        n_tests++; if (got_addr.size() != 0 || first_vld != -1) begin n_fail++; $display("FAIL t5_activity got ce %0d valid_at %0d want 0/-1", got_addr.size(), first_vld); end
        n_tests++; if (min_at_done !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL t5_min got %h want 7fffffff", min_at_done); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 32; i++) mem[i] = 32'd1000 + 32'(i);
        run_slice(5'd0, 6'd33, 0, 100);
        n_tests++; if (tmo != 0 || got_data.size() != 33) begin n_fail++; $display("FAIL t7_count got %0d want 33", got_data.size()); end
        if (got_data.size() == 33) begin
            n_tests++; if (got_data[32] !== 32'd1000 || got_last[32] !== 1'b1 || got_last[31] !== 1'b0) begin n_fail++; $display("FAIL t7_wrap_entry got %0d/%b want 1000/1", got_data[32], got_last[32]); end
        end
        n_tests++; if (min_at_done !== 32'd1000) begin n_fail++; $display("FAIL t7_min got %0d want 1000", min_at_done); end
    endtask

    task automatic test_reset_mid();
        int xfer, seen, dn;
        for (int i = 20; i < 24; i++) mem[i] = 32'd655360;
        xfer = 0; seen = 0; dn = 0;
        @(negedge ap_clk);
        ap_start = 1'b1; base_addr = 5'd20; count = 6'd4; out_ready = 1'b1;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            #1;
            if (out_valid && xfer == 1) begin
                seen = 1;
                ap_rst_n = 1'b0;
                #1;
                n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin n_fail++; $display("FAIL t6_stream got %b/%h/%b want 0/0/0", out_valid, out_data, out_last); end
                n_tests++; if (h_ce0 !== 1'b0 || h_address0 !== 5'd0 || ap_done !== 1'b0) begin n_fail++; $display("FAIL t6_ctrl got ce %b addr %0d done %b", h_ce0, h_address0, ap_done); end
                n_tests++; if (min_val !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL t6_min got %h want 7fffffff", min_val); end
            end else if (out_valid) begin
                xfer++;
            end
        end
        n_tests++; if (seen == 0) begin n_fail++; $display("FAIL t6_second_xfer got none want 1"); end
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge ap_clk); #1;
            if (ap_done) dn++;
        end
        n_tests++; if (dn != 0) begin n_fail++; $display("FAIL t6_no_done got %0d want 0", dn); end
        run_slice(5'd20, 6'd4, 0, 40);
        n_tests++; if (tmo != 0 || got_data.size() != 4 || done_cnt != 1) begin n_fail++; $display("FAIL t6_restart got %0d/%0d want 4/1", got_data.size(), done_cnt); end
        n_tests++; if (min_at_done !== 32'd655360) begin n_fail++; $display("FAIL t6_restart_min got %h want 000a0000", min_at_done); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        test_reset();
        test_stream();
        test_min();
        test_backpressure();
        test_wrap();
        test_zero();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
